vga_coord_gen: RTL
==================

# vga_coord_gen

VGA 640x480@60 Hz raster timing generator for the game display path. Divides the system clock into a pixel enable, runs the horizontal and vertical position counters, and drives HSync/VSync to the connector. It publishes H_Coord/V_Coord to the combinational sprite and letter generators, which decode shapes from these coordinates. It also publishes Video_On so the colour mux blanks outside the visible area.

## Interface
- CLK_DIV, 2: system clocks per pixel; minimum 1. Default gives 25 MHz from 50 MHz.
- H_VISIBLE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segment lengths in pixels. H_TOTAL is their sum, 800.
- V_VISIBLE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segment lengths in lines. V_TOTAL is their sum, 525.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- Pix_En  out  1  one-clk pulse per pixel; counters and sync outputs update only on it.
- H_Coord  out  10  horizontal counter, 0..H_TOTAL-1.
- V_Coord  out  10  vertical counter, 0..V_TOTAL-1.
- HSync  out  1  horizontal sync, active-low.
- VSync  out  1  vertical sync, active-low.
- Video_On  out  1  high when H_Coord<H_VISIBLE and V_Coord<V_VISIBLE.
- Frame_Start  out  1  one-clk pulse when the counters wrap to (0,0).
- Frame_Cnt  out  8  frame counter; present only with VGA_FRAME_CNT_EN.

## Operation
- Divider: div counts 0..CLK_DIV-1 every clk. Pix_En is a register, set high in the cycle after div reaches CLK_DIV-1. With CLK_DIV=1, Pix_En is constantly 1 after reset.
- Horizontal: on Pix_En, H_Coord increments. When H_Coord==H_TOTAL-1, it wraps to 0.
- Vertical: V_Coord increments only on a Pix_En where H wraps. When V_Coord==V_TOTAL-1 on that wrap, it wraps to 0.
- Sync decode, registered on the same Pix_En as the counters, from the next counter values, so sync and coordinates are always mutually consistent:
  - HSync=0 iff H in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. 656..751.
  - VSync=0 iff V in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. 490..491.
  - Video_On as defined in the interface.
- Frame_Start: set for exactly one clk on the Pix_En where both counters wrap; 0 otherwise.
- Reset values: div=0, Pix_En=0, H_Coord=0, V_Coord=0, HSync=1, VSync=1, Video_On=1, Frame_Start=0, Frame_Cnt=0.
- Reset mid-frame: the next clk edge with rst_n=0 forces all reset values, regardless of Pix_En or position. No partial line is completed.
- Width rule: all counter arithmetic is 10-bit unsigned. Totals must not exceed 1024; the parameter defaults satisfy this.

## Timing
- Pix_En: first pulse is CLK_DIV clks after the first edge with rst_n=1. Subsequent pulses every CLK_DIV clks.
- Coordinates, HSync, VSync and Video_On change only on Pix_En cycles. They hold steady for CLK_DIV clks.
- Line period: H_TOTAL*CLK_DIV = 1600 clks. Frame period: 525*1600 = 840000 clks.
- Frame_Start is coincident with the cycle H_Coord and V_Coord become 0. Consumers latch per-frame game state on it.
- No combinational path from any input to any output.

## Configuration
- VGA_FRAME_CNT_EN defined:
  - Frame_Cnt port exists and increments by 1 on every Frame_Start cycle.
  - Wraps 255→0.
  - Reset to 0.
  - Used for blink and animation timing on the win screen.
- Not defined: Frame_Cnt port and register are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 5 clks → Pix_En=0, H=0, V=0, HSync=1, VSync=1, Video_On=1, Frame_Start=0. First Pix_En is 2 clks after release.
- Horizontal sweep: run 1 line → H visits 0..799 once each, 2 clks apart. HSync=0 exactly for H=656..751 (192 clks). Video_On falls when H=640. V goes 0→1 when H wraps.
- Vertical sweep: run 1 frame → VSync=0 exactly for V=490..491 (3200 clks). Video_On=0 for all V≥480. Frame_Start pulses once, at clk 840000 after the first Pix_En, with H=V=0.
- Mid-frame reset: assert rst_n=0 at H=700, V=300 → next edge restores all reset values. Count resumes from (0,0) with no extra Frame_Start.
- CLK_DIV=1 build: Pix_En is constant 1 after reset. Line is 800 clks; frame is 420000 clks.
- With VGA_FRAME_CNT_EN: run 257 frames → Frame_Cnt reads 255 after 255 frames, 0 after 256 and 1 after 257. It changes only on Frame_Start cycles.

Source files
------------

// File: rtl/vga_coord_gen.sv
// VGA raster timing generator: pixel-enable divider, H/V position counters and registered sync/blanking decode.
// Optional frame counter output is built when VGA_FRAME_CNT_EN is defined.
module vga_coord_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       Pix_En,
  output logic [9:0] H_Coord,
  output logic [9:0] V_Coord,
  output logic       HSync,
  output logic       VSync,
  output logic       Video_On,
  output logic       Frame_Start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] Frame_Cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [9:0]       h_next;
  logic [9:0]       v_next;

  assign tick = (div == DIV_LAST);

  // Counters advance on the same edge that raises Pix_En, so the new
  // coordinates are visible exactly in the Pix_En cycle.
  always_comb begin
    h_wrap = (H_Coord == H_LAST);
    v_wrap = (V_Coord == V_LAST);
    h_next = h_wrap ? 10'd0 : H_Coord + 10'd1;
    v_next = V_Coord;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : V_Coord + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div    <= '0;
      Pix_En <= 1'b0;
    end else begin
      div    <= tick ? '0 : div + 1'b1;
      Pix_En <= tick;
    end
  end

  // Sync and blanking decode from the next coordinates keeps them aligned
  // with H_Coord/V_Coord on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      H_Coord     <= 10'd0;
      V_Coord     <= 10'd0;
      HSync       <= 1'b1;
      VSync       <= 1'b1;
      Video_On    <= 1'b1;
      Frame_Start <= 1'b0;
    end else begin
      Frame_Start <= tick & h_wrap & v_wrap;
      if (tick) begin
        H_Coord  <= h_next;
        V_Coord  <= v_next;
        HSync    <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
        VSync    <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        Video_On <= (h_next < H_VIS) && (v_next < V_VIS);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Frame_Cnt <= 8'd0;
    end else if (tick && h_wrap && v_wrap) begin
      Frame_Cnt <= Frame_Cnt + 8'd1;
    end
  end
`endif

endmodule
